// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES encrypt/decrypt round controllers:
// FSM state encoding, error codes and the default round count.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARK0,
        ST_SUB,
        ST_SHF,
        ST_MC,
        ST_ARK,
        ST_OUT
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNEXP = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_START = 2'b11;

    localparam int unsigned N_ROUNDS_DEF = 14;

    function automatic logic is_stage(state_e s);
        return (s == ST_ARK0) || (s == ST_SUB) || (s == ST_SHF) ||
               (s == ST_MC) || (s == ST_ARK);
    endfunction

endpackage

// File: rtl/aes_stage_timer.sv
// Stage watchdog: reloads on every stage entry, counts down to zero
// and saturates there; expired_o marks the TMO_CYC-th cycle in a stage.
module aes_stage_timer #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// AES encryption round sequencer: drives the SubBytes/ShiftRows/
// MixColumns/AddRoundKey handshakes, round-key index and error flags.
module aes_enc_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned N_ROUNDS = N_ROUNDS_DEF,
    parameter int unsigned RND_W    = 4,
    parameter int unsigned TMO_CYC  = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sub_start,
    input  logic             sub_done,
    output logic             shf_start,
    input  logic             shf_done,
    output logic             mc_start,
    input  logic             mc_done,
    output logic             ark_start,
    input  logic             ark_done,
    output logic [RND_W-1:0] key_sel,
    output logic             mux_sel,
    output logic [RND_W-1:0] round,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [RND_W-1:0] LAST = RND_W'(N_ROUNDS);

    state_e           state_q;
    state_e           state_d;
    logic             entry_q;
    logic             entry_d;
    logic [RND_W-1:0] round_q;
    logic [RND_W-1:0] round_d;
    logic [RND_W-1:0] key_q;
    logic [RND_W-1:0] key_d;
    logic             mux_q;
    logic             mux_d;
    logic             err_q;
    logic             err_d;
    logic [1:0]       code_q;
    logic [1:0]       code_d;

    logic             own_done;
    logic             stray;
    logic             in_stage;
    logic             fwd;
    logic             kill;
    logic [1:0]       new_code;
    logic             tmo_exp;

    aes_stage_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clr_i     (entry_d),
        .expired_o (tmo_exp)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            entry_q <= 1'b0;
            round_q <= '0;
            key_q   <= '0;
            mux_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            round_q <= round_d;
            key_q   <= key_d;
            mux_q   <= mux_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        own_done = 1'b0;
        stray    = 1'b0;
        unique case (state_q)
            ST_ARK0, ST_ARK: begin
                own_done = ark_done;
                stray    = sub_done | shf_done | mc_done;
            end
            ST_SUB: begin
                own_done = sub_done;
                stray    = shf_done | mc_done | ark_done;
            end
            ST_SHF: begin
                own_done = shf_done;
                stray    = sub_done | mc_done | ark_done;
            end
            ST_MC: begin
                own_done = mc_done;
                stray    = sub_done | shf_done | ark_done;
            end
            default: ;
        endcase

        in_stage = is_stage(state_q);
        // a done coinciding with its own start is a protocol error, not progress
        fwd      = in_stage && own_done && !entry_q;
        kill     = in_stage && tmo_exp && !fwd;

        new_code = ERR_NONE;
        if (in_stage && stray) begin
            new_code = ERR_UNEXP;
        end
        if (kill) begin
            new_code = ERR_TMO;
        end
        if (in_stage && own_done && entry_q) begin
            new_code = ERR_START;
        end

        state_d = state_q;
        round_d = round_q;
        err_d   = err_q;
        code_d  = code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ARK0;
                    round_d = '0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                end
            end
            ST_ARK0: begin
                if (fwd) begin
                    state_d = ST_SUB;
                    round_d = RND_W'(1);
                end
            end
            ST_SUB: begin
                if (fwd) begin
                    state_d = ST_SHF;
                end
            end
            ST_SHF: begin
                if (fwd) begin
                    state_d = (round_q < LAST) ? ST_MC : ST_ARK;
                end
            end
            ST_MC: begin
                if (fwd) begin
                    state_d = ST_ARK;
                end
            end
            ST_ARK: begin
                if (fwd) begin
                    if (round_q < LAST) begin
                        state_d = ST_SUB;
                        round_d = round_q + 1'b1;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (kill) begin
            state_d = ST_IDLE;
            round_d = '0;
        end

        if (new_code != ERR_NONE) begin
            err_d  = 1'b1;
            code_d = new_code;
        end

        entry_d = is_stage(state_d) && (state_d != state_q);

        key_d = key_q;
        if ((state_d == ST_ARK0) || (state_d == ST_ARK)) begin
            key_d = round_d;
        end

        // mux keeps its last setting while idle so reset leaves it at 0
        mux_d = mux_q;
        if (state_d == ST_ARK0) begin
            mux_d = 1'b0;
        end else if (state_d != ST_IDLE) begin
            mux_d = 1'b1;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
        sub_start = entry_q && (state_q == ST_SUB);
        shf_start = entry_q && (state_q == ST_SHF);
        mc_start  = entry_q && (state_q == ST_MC);
        ark_start = entry_q && ((state_q == ST_ARK0) || (state_q == ST_ARK));
        key_sel   = key_q;
        mux_sel   = mux_q;
        round     = round_q;
        err       = err_q;
        err_code  = code_q;
    end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: a 14-round and a 10-round instance
// driven by a randomized stage responder and a transaction-level model.
module tb_aes_enc_round_ctrl;

    localparam int TMO     = 255;
    localparam int S_SUB   = 0;
    localparam int S_SHF   = 1;
    localparam int S_MC    = 2;
    localparam int S_ARK   = 3;
    localparam int F_NONE  = 0;
    localparam int F_STRAY = 1;
    localparam int F_EARLY = 2;
    localparam int F_TMO   = 3;
    localparam int F_RST   = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       out_ready;
    logic       sel;
    logic [3:0] dn;

    logic [1:0] ir_s, ov_s, sub_s, shf_s, mc_s, ark_s, mux_s, err_s;
    logic [3:0] key_w  [2];
    logic [3:0] rnd_w  [2];
    logic [1:0] code_w [2];

    logic [3:0] o_start;
    logic       o_ir, o_ov, o_mux, o_err;
    logic [3:0] o_key, o_rnd;
    logic [1:0] o_code;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    int first_out;
    int cnt [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        aes_enc_round_ctrl #(
            .N_ROUNDS (g == 0 ? 14 : 10)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .in_valid  (in_valid && (sel == 1'(g))),
            .in_ready  (ir_s[g]),
            .out_valid (ov_s[g]),
            .out_ready (out_ready && (sel == 1'(g))),
            .sub_start (sub_s[g]),
            .sub_done  (dn[3] && (sel == 1'(g))),
            .shf_start (shf_s[g]),
            .shf_done  (dn[2] && (sel == 1'(g))),
            .mc_start  (mc_s[g]),
            .mc_done   (dn[1] && (sel == 1'(g))),
            .ark_start (ark_s[g]),
            .ark_done  (dn[0] && (sel == 1'(g))),
            .key_sel   (key_w[g]),
            .mux_sel   (mux_s[g]),
            .round     (rnd_w[g]),
            .err       (err_s[g]),
            .err_code  (code_w[g])
        );
    end

    assign o_start = {sub_s[sel], shf_s[sel], mc_s[sel], ark_s[sel]};
    assign o_ir    = ir_s[sel];
    assign o_ov    = ov_s[sel];
    assign o_mux   = mux_s[sel];
    assign o_err   = err_s[sel];
    assign o_key   = key_w[sel];
    assign o_rnd   = rnd_w[sel];
    assign o_code  = code_w[sel];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (o_start[3-i]) cnt[i]++;
        end
        if (o_ov && first_out < 0) first_out = cyc;
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", o_ir, 1);
        chk("rst_out_valid", o_ov, 0);
        chk("rst_start", o_start, 0);
        chk("rst_key", o_key, 0);
        chk("rst_mux", o_mux, 0);
        chk("rst_round", o_rnd, 0);
        chk("rst_err", o_err, 0);
        chk("rst_code", o_code, 0);
    endtask

    task automatic run_block(input int nr, input int lmin, input int lmax,
                             input int bp, input int fk, input int fidx);
        int         st_q [$];
        int         rd_q [$];
        int         lat;
        int         sum;
        logic       exp_err;
        logic [1:0] exp_code;
        logic [3:0] one;
        logic [3:0] own;
        logic [3:0] stray;

        one = 4'b1000;
        st_q.push_back(S_ARK);
        rd_q.push_back(0);
        for (int r = 1; r <= nr; r++) begin
            st_q.push_back(S_SUB); rd_q.push_back(r);
            st_q.push_back(S_SHF); rd_q.push_back(r);
            if (r < nr) begin
                st_q.push_back(S_MC); rd_q.push_back(r);
            end
            st_q.push_back(S_ARK); rd_q.push_back(r);
        end

        exp_err  = 1'b0;
        exp_code = 2'b00;
        sum      = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        first_out = -1;
        cyc       = 0;

        chk("idle_ready", o_ir, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;

        for (int i = 0; i < st_q.size(); i++) begin
            own   = one >> st_q[i];
            stray = one >> ((st_q[i] + 1) % 4);
            chk("start", o_start, own);
            chk("round", o_rnd, rd_q[i]);
            chk("key", o_key, (st_q[i] == S_ARK) ? rd_q[i] : rd_q[i] - 1);
            chk("mux", o_mux, (i == 0) ? 0 : 1);
            chk("busy", o_ir, 0);
            chk("err_run", o_err, exp_err);
            chk("code_run", o_code, exp_code);

            lat = $urandom_range(lmax, lmin);
            if (i == fidx && fk == F_TMO) begin
                for (int j = 1; j < TMO; j++) tick();
                chk("tmo_pending_err", o_err, 0);
                chk("tmo_pending_busy", o_ir, 0);
                tick();
                chk("tmo_err", o_err, 1);
                chk("tmo_code", o_code, 2);
                chk("tmo_idle", o_ir, 1);
                chk("tmo_round", o_rnd, 0);
                return;
            end
            if (i == fidx && fk == F_RST) begin
                tick();
                resetn = 1'b0;
                dn     = own;
                tick();
                resetn = 1'b1;
                dn     = 4'b0000;
                chk_reset();
                return;
            end
            if (i == fidx && lat < 3) lat = 3;
            if (i == fidx && fk == F_EARLY) dn = own;
            for (int j = 1; j <= lat; j++) begin
                tick();
                dn = 4'b0000;
                if (i == fidx && fk == F_EARLY && j == 1) begin
                    exp_err  = 1'b1;
                    exp_code = 2'b11;
                end
                if (i == fidx && fk == F_STRAY && j == 2) begin
                    exp_err  = 1'b1;
                    exp_code = 2'b01;
                end
                chk("stall_start", o_start, 0);
                chk("stall_err", o_err, exp_err);
                chk("stall_code", o_code, exp_code);
                if (i == fidx && fk == F_STRAY && j == 1) dn = stray;
                if (j == lat) dn = own;
            end
            tick();
            dn = 4'b0000;
            sum += lat + 1;
        end

        chk("out_cycle", first_out, 1 + sum);
        if (lmin == 1 && lmax == 1 && fk == F_NONE) begin
            chk("out_cycle_min", first_out, 8 * nr + 1);
        end
        chk("sub_pulses", cnt[S_SUB], nr);
        chk("shf_pulses", cnt[S_SHF], nr);
        chk("mc_pulses", cnt[S_MC], nr - 1);
        chk("ark_pulses", cnt[S_ARK], nr + 1);
        chk("out_valid", o_ov, 1);
        chk("out_busy", o_ir, 0);
        chk("out_err", o_err, exp_err);
        chk("out_code", o_code, exp_code);
        chk("out_key", o_key, nr);
        for (int b = 0; b < bp; b++) begin
            tick();
            chk("bp_valid", o_ov, 1);
            chk("bp_busy", o_ir, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("done_idle", o_ir, 1);
        chk("done_valid", o_ov, 0);
        chk("done_round", o_rnd, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dn        = 4'b0000;
        sel       = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset();
        resetn = 1'b1;
        @(negedge clk);

        run_block(14, 1, 1, 0, F_NONE, -1);
        run_block(14, 1, 1, 20, F_NONE, -1);
        for (int k = 0; k < 3; k++) begin
            run_block(14, 1, 4, $urandom_range(3, 0), F_NONE, -1);
        end
        run_block(14, 1, 3, 0, F_STRAY, 1);
        run_block(14, 1, 3, 0, F_EARLY, 1);
        run_block(14, 1, 2, 0, F_TMO, 19);
        run_block(14, 1, 2, 0, F_RST, 28);
        run_block(14, 1, 3, 1, F_NONE, -1);

        sel = 1'b1;
        @(negedge clk);
        run_block(10, 1, 1, 0, F_NONE, -1);
        for (int k = 0; k < 2; k++) begin
            run_block(10, 1, 4, $urandom_range(3, 0), F_NONE, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_enc_round_ctrl.md
# aes_enc_round_ctrl

Round sequencer for the AES-256 encryption datapath. It accepts one 128-bit block request and drives the stage handshakes in order: SubBytes ROM, ShiftRows, MixColumns and AddRoundKey. It also drives the round-key index and the AddRoundKey input-select mux. It replaces the ad-hoc round counter in the top level with a single FSM that owns the round count, detects protocol errors and times out hung stages.

## Interface
**Parameters**
- `N_ROUNDS`, default 14: number of full rounds; 10/12/14 are legal.
- `RND_W`, default 4: width of the round counter and key index.
- `TMO_CYC`, default 255: maximum wait for a stage `done`, in cycles.

**Ports**
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  a plaintext block is present at the datapath input.
- `in_ready`  out  1  controller is idle and can accept a block.
- `out_valid`  out  1  ciphertext is present at the AddRoundKey output.
- `out_ready`  in  1  consumer accepts the ciphertext.
- `sub_start` / `sub_done`  out / in  1 each  SubBytes stage handshake.
- `shf_start` / `shf_done`  out / in  1 each  ShiftRows stage handshake.
- `mc_start` / `mc_done`  out / in  1 each  MixColumns stage handshake.
- `ark_start` / `ark_done`  out / in  1 each  AddRoundKey stage handshake.
- `key_sel`  out  RND_W  round-key index for the key ROM.
- `mux_sel`  out  1  0 = plaintext feeds AddRoundKey; 1 = MixColumns/ShiftRows result feeds AddRoundKey.
- `round`  out  RND_W  current round number, for debug.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  01 = unexpected done, 10 = timeout, 11 = done in start cycle.

## Operation
- **States:** IDLE, ARK0, SUB, SHF, MC, ARK, OUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: go to ARK0, set `round`=0, clear `err`/`err_code`.
- **Stage states (ARK0, SUB, SHF, MC, ARK)**
  - The entry cycle asserts that stage's `*_start` for exactly 1 cycle.
  - The FSM then waits for the matching `*_done`.
  - A matching done in the entry cycle is ignored and sets `err`, `err_code`=11.
- **Transitions**
  - ARK0 done → SUB; `round` becomes 1.
  - SUB done → SHF.
  - SHF done → MC if `round`<`N_ROUNDS`; SHF done → ARK if `round`=`N_ROUNDS` (final round skips MixColumns).
  - MC done → ARK.
  - ARK done → SUB with `round`+1 if `round`<`N_ROUNDS`; ARK done → OUT if `round`=`N_ROUNDS`.
- **Outputs by state**
  - `key_sel` = `round` in ARK0 and ARK; it holds its value elsewhere.
  - `mux_sel` = 0 only in ARK0 and 1 otherwise.
- **OUT:** `out_valid`=1 until `out_ready`; then go to IDLE with `round`=0.
- **Unexpected done:** a done from a stage that is not the current one sets `err`, `err_code`=01. The FSM does not change state.
- **Timeout:** a stage state that exceeds `TMO_CYC` cycles without its done sets `err`, `err_code`=10, and forces IDLE. The in-flight block is dropped.
- **Error precedence:** if several errors occur in one cycle, the higher `err_code` wins. `err` stays set until the next accepted block.
- **Reset (including mid-operation):** next edge gives state IDLE, `round`=0, `key_sel`=0, `mux_sel`=0, and all `*_start`, `out_valid`, `err`, `err_code` at 0. Any pending dones are discarded.

## Timing
- Acceptance happens on the edge where `in_valid`&&`in_ready`. `ark_start` is high in the next cycle.
- A stage takes at least 2 cycles: the start cycle plus the done cycle. The next stage's start is in the cycle after done.
- Minimum accept-to-`out_valid` is 2×(1+4·(N_ROUNDS−1)+3) = 112 cycles for `N_ROUNDS`=14.
- `in_ready` is 0 from acceptance until the cycle after the OUT handshake. There is no back-to-back overlap.
- Done inputs are single-cycle pulses, sampled at the rising edge. A level held high counts once per stage entry.
- The timeout counter resets on each stage entry. It saturates and fires on the cycle its count equals `TMO_CYC`.

## Structure
- **Package `aes_ctrl_pkg`:** holds the state enum, the `err_code` encodings and the default `N_ROUNDS`. It is shared with the decryption controller.
- **Sub-module `aes_stage_timer`:** a loadable down-counter with a clear on stage entry and an `expired` output, instantiated once.
- **Main module:** one FSM plus the round counter.

## Test plan
- **Nominal run:** `in_valid` for 1 cycle; every done returned 1 cycle after its start. Expect `out_valid` at cycle 113, `key_sel` sequence 0,1…14, 13 `mc_start` pulses, 14 `sub_start` pulses.
- **Output backpressure:** hold `out_ready`=0 for 20 cycles. Expect `out_valid` stable, `in_ready`=0, then IDLE in the cycle after `out_ready`.
- **Timeout:** withhold `mc_done` in round 5. Expect `err`=1 and `err_code`=10 after 255 cycles, then IDLE with `round`=0.
- **Protocol errors:**
  - Pulse `shf_done` during SUB: expect `err_code`=01 and no state change.
  - Pulse `sub_done` in the same cycle as `sub_start`: expect `err_code`=11 and the FSM keeps waiting.
- **Reset mid-operation:** `resetn`=0 in round 7 (ARK state). Expect all outputs at their reset values at the next edge; a new block then completes normally.
- **Parameter variant:** `N_ROUNDS`=10. Expect `out_valid` at cycle 81 and `key_sel` ending at 10.
